// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath/memory.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        iord;
  logic        memwrite;
  logic        irwrite;
  logic        pcen;
  logic [1:0]  pcsrc;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        immzext;
  logic [2:0]  alucontrol;
  logic        regwrite;
  logic        regdst;
  logic [1:0]  memtoreg;
  logic        done;
  logic        halted;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           immzext, alucontrol, regwrite, regdst, memtoreg, done, halted
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           immzext, alucontrol, regwrite, regdst, memtoreg, done, halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset datapath with a memory wait watchdog.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, BRANCH, JUMP, LUIWB, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b000;
  localparam logic [2:0] ALU_UND = 3'b011;

  localparam logic [8:0] TO = 9'(TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [8:0] wait_inc;
  logic       expired;
  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr;

  assign op           = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];

  // The access times out when this waiting cycle would bring the count up to TIMEOUT.
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;
  assign expired  = (TO != 9'd0) && !bus.mem_ready && (wait_inc >= TO);

  // State register and memory wait counter (cleared whenever the state changes).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (bus.mem_req && !bus.mem_ready && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Next-state and control output decode.
  always_comb begin
    state_next     = state;
    bus.mem_req    = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcen       = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.immzext    = 1'b0;
    bus.alucontrol = ALU_UND;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 2'b00;
    bus.done       = 1'b0;
    bus.halted     = 1'b0;

    case (state)
      IDLE: state_next = FETCH;

      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alusrcb    = 2'b01;
        bus.alucontrol = ALU_ADD;
        bus.irwrite    = bus.mem_ready;
        bus.pcen       = bus.mem_ready;
        if (bus.mem_ready)
          state_next = DECODE;
        else if (expired)
          state_next = HALT;
      end

      DECODE: begin
        bus.alusrcb    = 2'b11;
        bus.alucontrol = ALU_ADD;
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLTU: state_next = EXEC;
              default:                                  state_next = HALT;
            endcase
          end
          OP_ADDIU, OP_ORI: state_next = EXEC;
          OP_LW, OP_SW:     state_next = MEMADR;
          OP_BEQ, OP_BLTZ:  state_next = BRANCH;
          OP_J:             state_next = JUMP;
          OP_LUI:           state_next = LUIWB;
          default:          state_next = HALT;
        endcase
      end

      EXEC: begin
        bus.alusrca = 1'b1;
        if (op == OP_RTYPE) begin
          bus.alusrcb = 2'b00;
          case (funct)
            FN_ADDU: bus.alucontrol = ALU_ADD;
            FN_SUBU: bus.alucontrol = ALU_SUB;
            FN_AND:  bus.alucontrol = ALU_AND;
            FN_OR:   bus.alucontrol = ALU_OR;
            FN_SLTU: bus.alucontrol = ALU_SLT;
            default: bus.alucontrol = ALU_UND;
          endcase
        end else if (op == OP_ORI) begin
          bus.alusrcb    = 2'b10;
          bus.immzext    = 1'b1;
          bus.alucontrol = ALU_OR;
        end else begin
          bus.alusrcb    = 2'b10;
          bus.alucontrol = ALU_ADD;
        end
        state_next = ALUWB;
      end

      ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = (op == OP_RTYPE);
        bus.done     = 1'b1;
        state_next   = FETCH;
      end

      MEMADR: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = ALU_ADD;
        state_next     = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end

      MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready)
          state_next = MEMWB;
        else if (expired)
          state_next = HALT;
      end

      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 2'b01;
        bus.done     = 1'b1;
        state_next   = FETCH;
      end

      MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        bus.done     = bus.mem_ready;
        if (bus.mem_ready)
          state_next = FETCH;
        else if (expired)
          state_next = HALT;
      end

      BRANCH: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b00;
        bus.pcsrc   = 2'b01;
        bus.done    = 1'b1;
        if (op == OP_BEQ) begin
          bus.alucontrol = ALU_SUB;
          bus.pcen       = bus.zero;
        end else begin
          bus.alucontrol = ALU_SLT;
          bus.pcen       = ~bus.zero;
        end
        state_next = FETCH;
      end

      JUMP: begin
        bus.pcsrc  = 2'b10;
        bus.pcen   = 1'b1;
        bus.done   = 1'b1;
        state_next = FETCH;
      end

      LUIWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 2'b10;
        bus.done     = 1'b1;
        state_next   = FETCH;
      end

      HALT: bus.halted = 1'b1;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: output vectors per state and instruction lengths.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  logic rst1;

  multicycle_controller_if if0 ();
  multicycle_controller_if if1 ();

  multicycle_controller #(.TIMEOUT(255)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  multicycle_controller #(.TIMEOUT(3))   dut1 (.clk(clk), .reset(rst1),  .bus(if1.master));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [19:0] o0, o1;
  assign o0 = {if0.mem_req, if0.iord, if0.memwrite, if0.irwrite, if0.pcen, if0.pcsrc,
               if0.alusrca, if0.alusrcb, if0.immzext, if0.alucontrol, if0.regwrite,
               if0.regdst, if0.memtoreg, if0.done, if0.halted};
  assign o1 = {if1.mem_req, if1.iord, if1.memwrite, if1.irwrite, if1.pcen, if1.pcsrc,
               if1.alusrca, if1.alusrcb, if1.immzext, if1.alucontrol, if1.regwrite,
               if1.regdst, if1.memtoreg, if1.done, if1.halted};

  function automatic logic [19:0] pk(
    input logic mreq, input logic iord, input logic mw, input logic irw, input logic pcen,
    input logic [1:0] pcsrc, input logic asa, input logic [1:0] asb, input logic zext,
    input logic [2:0] alu, input logic rw, input logic rd, input logic [1:0] m2r,
    input logic dn, input logic hl);
    return {mreq, iord, mw, irw, pcen, pcsrc, asa, asb, zext, alu, rw, rd, m2r, dn, hl};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect0(input string tag, input logic [19:0] exp);
    #1;
    check_val(tag, {12'h0, o0}, {12'h0, exp});
  endtask

  logic [19:0] E_IDLE, E_FETCH_R, E_FETCH_W, E_DECODE, E_ALUWB_R, E_ALUWB_I, E_EXEC_ORI,
               E_EXEC_ADDIU, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE_R, E_MEMWRITE_W,
               E_BEQ_T, E_BEQ_F, E_BLTZ_T, E_BLTZ_F, E_JUMP, E_LUI, E_HALT;

  // One ALU-type instruction starting in FETCH, ending in the following FETCH.
  task automatic run_alu(input string tag, input logic [31:0] ins,
                         input logic [19:0] e_exec, input logic [19:0] e_wb);
    int t0;
    if0.instr     = ins;
    if0.mem_ready = 1'b1;
    expect0({tag, "_fetch"}, E_FETCH_R);
    t0 = cyc;
    step(); expect0({tag, "_decode"}, E_DECODE);
    step(); expect0({tag, "_exec"}, e_exec);
    step(); expect0({tag, "_wb"}, e_wb);
    step(); expect0({tag, "_next_fetch"}, E_FETCH_R);
    check_val({tag, "_cycles"}, cyc - t0, 4);
  endtask

  logic [5:0] fn_tab  [5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011};
  logic [2:0] alu_tab [5] = '{3'b101, 3'b001, 3'b111, 3'b110, 3'b000};

  initial begin
    int t0;
    E_IDLE       = pk(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,0,0,2'b00,0,0);
    E_FETCH_R    = pk(1,0,0,1,1,2'b00,0,2'b01,0,3'b101,0,0,2'b00,0,0);
    E_FETCH_W    = pk(1,0,0,0,0,2'b00,0,2'b01,0,3'b101,0,0,2'b00,0,0);
    E_DECODE     = pk(0,0,0,0,0,2'b00,0,2'b11,0,3'b101,0,0,2'b00,0,0);
    E_ALUWB_R    = pk(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,1,1,2'b00,1,0);
    E_ALUWB_I    = pk(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,1,0,2'b00,1,0);
    E_EXEC_ORI   = pk(0,0,0,0,0,2'b00,1,2'b10,1,3'b110,0,0,2'b00,0,0);
    E_EXEC_ADDIU = pk(0,0,0,0,0,2'b00,1,2'b10,0,3'b101,0,0,2'b00,0,0);
    E_MEMADR     = pk(0,0,0,0,0,2'b00,1,2'b10,0,3'b101,0,0,2'b00,0,0);
    E_MEMREAD    = pk(1,1,0,0,0,2'b00,0,2'b00,0,3'b011,0,0,2'b00,0,0);
    E_MEMWB      = pk(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,1,0,2'b01,1,0);
    E_MEMWRITE_R = pk(1,1,1,0,0,2'b00,0,2'b00,0,3'b011,0,0,2'b00,1,0);
    E_MEMWRITE_W = pk(1,1,1,0,0,2'b00,0,2'b00,0,3'b011,0,0,2'b00,0,0);
    E_BEQ_T      = pk(0,0,0,0,1,2'b01,1,2'b00,0,3'b001,0,0,2'b00,1,0);
    E_BEQ_F      = pk(0,0,0,0,0,2'b01,1,2'b00,0,3'b001,0,0,2'b00,1,0);
    E_BLTZ_T     = pk(0,0,0,0,1,2'b01,1,2'b00,0,3'b000,0,0,2'b00,1,0);
    E_BLTZ_F     = pk(0,0,0,0,0,2'b01,1,2'b00,0,3'b000,0,0,2'b00,1,0);
    E_JUMP       = pk(0,0,0,0,1,2'b10,0,2'b00,0,3'b011,0,0,2'b00,1,0);
    E_LUI        = pk(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,1,0,2'b10,1,0);
    E_HALT       = pk(0,0,0,0,0,2'b00,0,2'b00,0,3'b011,0,0,2'b00,0,1);

    reset = 1'b0; rst1 = 1'b0;
    if0.instr = '0; if0.zero = 1'b0; if0.mem_ready = 1'b1;
    if1.instr = '0; if1.zero = 1'b0; if1.mem_ready = 1'b0;

    step(); expect0("reset_idle", E_IDLE);
    reset = 1'b1;
    expect0("release_idle", E_IDLE);
    step(); expect0("first_fetch", E_FETCH_R);

    // R-type group: every legal funct with its ALU code
    for (int i = 0; i < 5; i++)
      run_alu("rtype", {26'h0, fn_tab[i]},
              pk(0,0,0,0,0,2'b00,1,2'b00,0,alu_tab[i],0,0,2'b00,0,0), E_ALUWB_R);
    run_alu("addiu", 32'h2400_0004, E_EXEC_ADDIU, E_ALUWB_I);
    run_alu("ori",   32'h3400_00FF, E_EXEC_ORI,   E_ALUWB_I);

    // lw with two wait cycles in MEMREAD
    if0.instr = 32'h8C00_0000;
    t0 = cyc;
    step(); expect0("lw_decode", E_DECODE);
    step(); expect0("lw_memadr", E_MEMADR);
    step(); if0.mem_ready = 1'b0; expect0("lw_memread_w1", E_MEMREAD);
    step(); expect0("lw_memread_w2", E_MEMREAD);
    step(); if0.mem_ready = 1'b1; expect0("lw_memread_rdy", E_MEMREAD);
    step(); expect0("lw_memwb", E_MEMWB);
    step(); expect0("lw_next_fetch", E_FETCH_R);
    check_val("lw_cycles", cyc - t0, 7);

    // beq, both zero values in BRANCH
    if0.instr = 32'h1000_0000;
    t0 = cyc;
    step(); expect0("beq_decode", E_DECODE);
    step(); if0.zero = 1'b1; expect0("beq_taken", E_BEQ_T);
    if0.zero = 1'b0; expect0("beq_not_taken", E_BEQ_F);
    step(); expect0("beq_next_fetch", E_FETCH_R);
    check_val("beq_cycles", cyc - t0, 3);

    // bltz
    if0.instr = 32'h0400_0000;
    step(); expect0("bltz_decode", E_DECODE);
    step(); if0.zero = 1'b0; expect0("bltz_taken", E_BLTZ_T);
    if0.zero = 1'b1; expect0("bltz_not_taken", E_BLTZ_F);
    step(); expect0("bltz_next_fetch", E_FETCH_R);

    // j
    if0.instr = 32'h0800_0010;
    t0 = cyc;
    step(); expect0("j_decode", E_DECODE);
    step(); expect0("j_jump", E_JUMP);
    step(); expect0("j_next_fetch", E_FETCH_R);
    check_val("j_cycles", cyc - t0, 3);

    // lui
    if0.instr = 32'h3C00_1234;
    step(); expect0("lui_decode", E_DECODE);
    step(); expect0("lui_wb", E_LUI);
    step(); expect0("lui_next_fetch", E_FETCH_R);

    // sw, zero wait states
    if0.instr = 32'hAC00_0000;
    t0 = cyc;
    step(); expect0("sw_decode", E_DECODE);
    step(); expect0("sw_memadr", E_MEMADR);
    step(); expect0("sw_memwrite", E_MEMWRITE_R);
    step(); expect0("sw_next_fetch", E_FETCH_R);
    check_val("sw_cycles", cyc - t0, 4);

    // sw aborted by reset while waiting
    step(); expect0("sw2_decode", E_DECODE);
    step(); expect0("sw2_memadr", E_MEMADR);
    step(); if0.mem_ready = 1'b0; expect0("sw2_memwrite_wait", E_MEMWRITE_W);
    reset = 1'b0;
    step(); expect0("sw2_reset_idle", E_IDLE);
    reset = 1'b1; if0.mem_ready = 1'b1;
    step(); expect0("sw2_refetch", E_FETCH_R);

    // illegal opcode halts and ignores inputs
    if0.instr = 32'hFC00_0000;
    step(); expect0("ill_decode", E_DECODE);
    step(); expect0("ill_halt", E_HALT);
    for (int i = 0; i < 10; i++) begin
      if0.instr     = $urandom;
      if0.zero      = 1'($urandom_range(0, 1));
      if0.mem_ready = 1'($urandom_range(0, 1));
      step(); expect0("ill_halt_hold", E_HALT);
    end
    reset = 1'b0;
    step(); expect0("ill_reset_idle", E_IDLE);
    reset = 1'b1; if0.mem_ready = 1'b1; if0.instr = 32'h0000_0000;
    step(); expect0("fn0_fetch", E_FETCH_R);

    // R-type with funct 000000 halts
    step(); expect0("fn0_decode", E_DECODE);
    step(); expect0("fn0_halt", E_HALT);
    reset = 1'b0;
    step(); expect0("fn0_reset_idle", E_IDLE);
    reset = 1'b1;

    // watchdog on the TIMEOUT=3 instance, mem_ready held low in FETCH
    rst1 = 1'b1;
    step(); #1; check_val("to_wait1", {12'h0, o1}, {12'h0, E_FETCH_W});
    step(); #1; check_val("to_wait2", {12'h0, o1}, {12'h0, E_FETCH_W});
    step(); #1; check_val("to_wait3", {12'h0, o1}, {12'h0, E_FETCH_W});
    step(); #1; check_val("to_halt",  {12'h0, o1}, {12'h0, E_HALT});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
